// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame-phase states and
// output mux select encodings used by the controller, serializer and mux.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [1:0] START_BIT = 2'b00;
  localparam logic [1:0] LINE_HIGH = 2'b01;
  localparam logic [1:0] SER_DATA  = 2'b10;
  localparam logic [1:0] PAR_BIT   = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Walks start, data, optional parity and stop
// phases, one line bit per clock, and strobes the datapath load on accept.
// A STOP phase may accept the next frame directly so frames run back-to-back.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       ser_en,
  output logic       data_load,
  output logic [1:0] mux_sel,
  output logic       busy
);

  // Counter must stay at least one bit wide even for single-bit frames.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;

  // State, bit counter and latched parity enable; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
    end
  end

  // Next-state, counter update, Moore phase outputs and Mealy load strobe.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = '0;
    par_en_d  = par_en_q;
    ser_en    = 1'b0;
    data_load = 1'b0;
    mux_sel   = LINE_HIGH;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Data_Valid && !rst) begin
          data_load = 1'b1;
          par_en_d  = PAR_EN;
          state_d   = START;
        end
      end
      START: begin
        mux_sel = START_BIT;
        busy    = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        mux_sel = SER_DATA;
        ser_en  = 1'b1;
        busy    = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        mux_sel = PAR_BIT;
        busy    = 1'b1;
        state_d = STOP;
      end
      STOP: begin
        busy = 1'b1;
        // Accepting here chains the next frame with no idle bit between.
        if (Data_Valid && !rst) begin
          data_load = 1'b1;
          par_en_d  = PAR_EN;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl. Accepted frames are expanded into a
// queue of expected per-cycle line phases; a negedge monitor pops and compares.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       ser_en;
  logic       data_load;
  logic [1:0] mux_sel;
  logic       busy;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Data_Valid(Data_Valid), .PAR_EN(PAR_EN),
    .ser_en(ser_en), .data_load(data_load), .mux_sel(mux_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       ser;
    logic [1:0] mux;
  } phase_t;

  phase_t exp_q[$];
  int     n_chk = 0;
  int     n_err = 0;
  bit     chk_en = 1'b0;
  int     dl_seen = 0;
  int     ser_seen = 0;
  int     busy_seen = 0;

  // Expand one accepted frame into its sequence of line phases.
  task automatic push_frame(input logic par);
    exp_q.push_back('{1'b1, 1'b0, START_BIT});
    for (int i = 0; i < W; i++) exp_q.push_back('{1'b1, 1'b1, SER_DATA});
    if (par) exp_q.push_back('{1'b1, 1'b0, PAR_BIT});
    exp_q.push_back('{1'b1, 1'b0, LINE_HIGH});
  endtask

  // Reference: a new frame is taken only when idle or on the last (stop) phase.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      automatic bit acc = Data_Valid && (exp_q.size() <= 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) push_frame(PAR_EN);
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // Monitor: compare DUT outputs with the head of the expected queue.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic phase_t e = (exp_q.size() > 0) ? exp_q[0] : '{1'b0, 1'b0, LINE_HIGH};
      automatic bit     dl = Data_Valid && !rst && (exp_q.size() <= 1);
      check("busy", int'(busy), int'(e.busy));
      check("ser_en", int'(ser_en), int'(e.ser));
      check("mux_sel", int'(mux_sel), int'(e.mux));
      check("data_load", int'(data_load), int'(dl));
    end
    if (data_load === 1'b1) dl_seen++;
    if (ser_en === 1'b1) ser_seen++;
    if (busy === 1'b1) busy_seen++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse Data_Valid once from idle and count the frame's busy/ser_en cycles.
  task automatic single_frame(input logic par);
    int b0, s0;
    b0 = busy_seen;
    s0 = ser_seen;
    PAR_EN = par; Data_Valid = 1'b1;
    cyc();
    Data_Valid = 1'b0;
    cyc(W + 6);
    check(par ? "busy_len_par" : "busy_len_nopar", busy_seen - b0, W + 2 + (par ? 1 : 0));
    check("ser_en_len", ser_seen - s0, W);
  endtask

  // Watchdog so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst = 1'b1; Data_Valid = 1'b1; PAR_EN = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc(3);
    rst = 1'b0; Data_Valid = 1'b0;
    cyc(2);

    single_frame(1'b1);
    single_frame(1'b0);

    // Back-to-back: Data_Valid held for 30 cycles starting from idle.
    d0 = dl_seen;
    PAR_EN = 1'b1; Data_Valid = 1'b1;
    cyc(30);
    Data_Valid = 1'b0;
    check("b2b_loads", dl_seen - d0, (30 + (W + 3) - 1) / (W + 3));
    cyc(W + 6);

    // Mid-frame PAR_EN drop and extra request during DATA are ignored.
    d0 = dl_seen;
    PAR_EN = 1'b1; Data_Valid = 1'b1;
    cyc();
    Data_Valid = 1'b0;
    cyc(3);
    PAR_EN = 1'b0; Data_Valid = 1'b1;
    cyc();
    Data_Valid = 1'b0;
    cyc(W + 4);
    check("midframe_loads", dl_seen - d0, 1);

    // Reset asserted in the 4th DATA cycle aborts the frame.
    PAR_EN = 1'b1; Data_Valid = 1'b1;
    cyc();
    Data_Valid = 1'b0;
    cyc(4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    cyc(2);
    single_frame(1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      Data_Valid = ($urandom_range(0, 99) < 35);
      PAR_EN     = $urandom_range(0, 1);
      rst        = ($urandom_range(0, 79) == 0);
      cyc();
    end
    rst = 1'b0; Data_Valid = 1'b0;
    cyc(W + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame-sequencing controller for the UART transmitter. It accepts a `Data_Valid` strobe, then drives the serializer, the parity calculator and the output mux through start, data, optional parity and stop phases. It owns the bit counter and the `busy` indication. The datapath blocks do only shifting, parity computation and selection.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; sets the bit-counter range.
- `clk`  in  1: transmit bit clock; one UART bit per cycle.
- `rst`  in  1: synchronous, active-high reset.
- `Data_Valid`  in  1: request to send `P_DATA`; sampled only when a new frame may be accepted.
- `PAR_EN`  in  1: parity bit enable; latched at frame accept.
- `ser_en`  out  1: serializer shift enable; high in every DATA cycle.
- `data_load`  out  1: load strobe; serializer and parity calculator capture `P_DATA` and `PAR_TYP` on this edge.
- `mux_sel`  out  2: output mux select (encodings under Structure).
- `busy`  out  1: high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Binary encoding, registered.
- IDLE: `mux_sel`=LINE_HIGH, `busy`=0. If `Data_Valid`=1, then `data_load`=1 (combinational), `PAR_EN` is latched into `par_en_q`, and the next state is START.
- START: `mux_sel`=START_BIT, `busy`=1. Next state is DATA with `bit_cnt`=0.
- DATA: `mux_sel`=SER_DATA, `ser_en`=1, `busy`=1.
  - `bit_cnt` increments each cycle.
  - When `bit_cnt`==DATA_WIDTH-1: next state is PARITY if `par_en_q`=1, else STOP. `bit_cnt` returns to 0.
- PARITY: `mux_sel`=PAR_BIT, `busy`=1. Next state is STOP.
- STOP: `mux_sel`=LINE_HIGH, `busy`=1.
  - If `Data_Valid`=1: `data_load`=1, `par_en_q` reloads, next state is START (back-to-back, no idle gap).
  - Else next state is IDLE.
- `Data_Valid` is ignored in START, DATA and PARITY. No queuing; the requester holds or re-asserts it.
- `PAR_EN` changes mid-frame have no effect on the current frame.
- `bit_cnt` width is $clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1 and holds 0 outside DATA.

## Timing
- `ser_en`, `mux_sel` and `busy` are Moore decodes of the registered state. `data_load` is Mealy (state ∈ {IDLE, STOP} && `Data_Valid`).
- Accept latency: `Data_Valid` sampled high at edge N means START is presented in the cycle after edge N.
- Frame length (`busy` high): 1 + DATA_WIDTH + `par_en_q` + 1 cycles. That is 10 cycles with parity off and 11 with parity on, for DATA_WIDTH=8.
- Reset dominates all inputs. On the first edge with `rst`=1:
  - state=IDLE, `bit_cnt`=0, `par_en_q`=0.
  - `busy`=0, `ser_en`=0, `mux_sel`=LINE_HIGH, `data_load`=0.
- Reset mid-frame aborts the frame. The line returns to high on the next cycle and there is no stop-bit completion.
- `Data_Valid` and `rst` high together: reset wins, `data_load`=0.

## Structure
- Shared package `uart_tx_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the `mux_sel` encodings START_BIT=2'b00, LINE_HIGH=2'b01, SER_DATA=2'b10, PAR_BIT=2'b11.
- The serializer and mux import the same package.
- Single module, no sub-modules. The bit counter lives inline with the FSM.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `Data_Valid`=1. Required: `busy`=0, `mux_sel`=01, `ser_en`=0, `data_load`=0 throughout.
- Parity-on frame: `PAR_EN`=1, `Data_Valid` pulsed for 1 cycle.
  - Required: `data_load` high 1 cycle, then `mux_sel` sequence 00, 10×8, 11, 01.
  - `ser_en` high exactly 8 cycles; `busy` high 11 cycles.
  - With the real datapath and `P_DATA`=8'hB9, `PAR_TYP`=0, the line reads 0,1,0,0,1,1,1,0,1,1,1.
- Parity-off frame: `PAR_EN`=0. Required: `mux_sel` sequence 00, 10×8, 01; `busy` high 10 cycles; PAR_BIT never selected.
- Back-to-back: `Data_Valid` held high for 30 cycles with `PAR_EN`=1.
  - Required: `busy` stays 1 continuously.
  - `data_load` pulses exactly at the IDLE-accept cycle and at each STOP cycle, i.e. every 11 cycles.
- Mid-frame changes: toggle `PAR_EN` from 1 to 0 and pulse `Data_Valid` during DATA. Required: the frame still includes PARITY, and no extra `data_load` occurs before STOP.
- Reset abort: assert `rst` for 1 cycle at the 4th DATA cycle. Required: the next cycle shows IDLE, `mux_sel`=01, `busy`=0, `bit_cnt`=0; a subsequent `Data_Valid` starts a full, correct frame.
